vga_ctrl: RTL and testbench

Raster timing generator for the 640x480@60 Hz VGA path. It clocks on the 25 MHz `vga_clk` and owns the horizontal and vertical counters. It drives `pix_x`/`pix_y` to the picture-generation block one cycle before each pixel is displayed, registers the returned `pix_data`, and emits `rgb`, `hsync`, `vsync` and a display-enable to the DAC/connector. It sits between the picture generator and the board pins.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_cnt.sv | 45 ++++
 rtl/vga_ctrl.sv | 102 ++++++++++
 tb/tb_vga_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing constants, RGB565 colors and raster helpers    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam int c_cnt_w = 10;
  typedef logic [c_cnt_w-1:0] cnt_t;
  typedef logic [15:0]        rgb565_t;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_VALID = 480;
  localparam int V_FRONT = 10;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  // Coordinate the picture generator sees when no pixel is being requested.
  localparam cnt_t c_pix_none = 10'h3FF;

  localparam rgb565_t c_rgb_black   = 16'h0000;
  localparam rgb565_t c_rgb_white   = 16'hFFFF;
  localparam rgb565_t c_rgb_red     = 16'hF800;
  localparam rgb565_t c_rgb_green   = 16'h07E0;
  localparam rgb565_t c_rgb_blue    = 16'h001F;
  localparam rgb565_t c_rgb_yellow  = 16'hFFE0;
  localparam rgb565_t c_rgb_cyan    = 16'h07FF;
  localparam rgb565_t c_rgb_magenta = 16'hF81F;
  localparam rgb565_t c_rgb_gray    = 16'h8410;

  function automatic logic in_span(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_cnt : wrapping raster counter (0..MAX) with enable and wrap flag       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vga_cnt
  import vga_pkg::*;
#(
  parameter int MAX = H_TOTAL - 1
) (
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic i_en,
  output cnt_t o_cnt,
  output cnt_t o_cnt_nxt,
  output logic o_wrap
);

  localparam cnt_t c_max = cnt_t'(MAX);

  cnt_t r_cnt;

  // The next value is exported so sync outputs can be registered in step with the count.
  always_comb begin
    o_wrap = i_en && (r_cnt == c_max);
    if (!i_en)
      o_cnt_nxt = r_cnt;
    else if (o_wrap)
      o_cnt_nxt = '0;
    else
      o_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_cnt <= '0;
    else
      r_cnt <= o_cnt_nxt;
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/vga_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_ctrl : VGA raster timing, pixel request and registered DAC outputs     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BACK   = vga_pkg::H_BACK,
  parameter int   H_VALID  = vga_pkg::H_VALID,
  parameter int   H_FRONT  = vga_pkg::H_FRONT,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BACK   = vga_pkg::V_BACK,
  parameter int   V_VALID  = vga_pkg::V_VALID,
  parameter int   V_FRONT  = vga_pkg::V_FRONT,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        de,
  output logic        frame_start
);

  localparam int c_h_total = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int c_v_total = V_SYNC + V_BACK + V_VALID + V_FRONT;

  // Requests run one clock ahead of the active area to cover the pix_data register.
  localparam cnt_t c_req_h_lo = cnt_t'(H_SYNC + H_BACK - 1);
  localparam cnt_t c_req_h_hi = cnt_t'(H_SYNC + H_BACK + H_VALID - 2);
  localparam cnt_t c_act_v_lo = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t c_act_v_hi = cnt_t'(V_SYNC + V_BACK + V_VALID - 1);
  localparam cnt_t c_h_sync   = cnt_t'(H_SYNC);
  localparam cnt_t c_v_sync   = cnt_t'(V_SYNC);

  cnt_t w_cnt_h;
  cnt_t w_h_nxt;
  logic w_h_wrap;
  cnt_t w_cnt_v;
  cnt_t w_v_nxt;
  logic w_v_wrap;
  logic w_req;

  vga_cnt #(
    .MAX (c_h_total - 1)
  ) u_cnt_h (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (1'b1),
    .o_cnt     (w_cnt_h),
    .o_cnt_nxt (w_h_nxt),
    .o_wrap    (w_h_wrap)
  );

  vga_cnt #(
    .MAX (c_v_total - 1)
  ) u_cnt_v (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (w_h_wrap),
    .o_cnt     (w_cnt_v),
    .o_cnt_nxt (w_v_nxt),
    .o_wrap    (w_v_wrap)
  );

  always_comb begin
    w_req = in_span(w_cnt_h, c_req_h_lo, c_req_h_hi) &&
            in_span(w_cnt_v, c_act_v_lo, c_act_v_hi);
    pix_x = c_pix_none;
    pix_y = c_pix_none;
    if (w_req) begin
      pix_x = w_cnt_h - c_req_h_lo;
      pix_y = w_cnt_v - c_act_v_lo;
    end
  end

  // The vertical counter only wraps on a horizontal wrap, so its wrap marks (0,0) next.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb         <= c_rgb_black;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      rgb         <= w_req ? pix_data : c_rgb_black;
      de          <= w_req;
      hsync       <= (w_h_nxt < c_h_sync) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (w_v_nxt < c_v_sync) ? SYNC_POL : ~SYNC_POL;
      frame_start <= w_v_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_ctrl : raster timing model plus pixel scoreboard for vga_ctrl       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_vga_ctrl;

  // Full horizontal timing; vertical shortened so several frames fit the run.
  localparam int HT = 800, HS = 96, HA = 144;
  localparam int VS = 2, VB = 3, VV = 4, VF = 2;
  localparam int VT = VS + VB + VV + VF;
  localparam int VA = VS + VB;
  localparam int FRAME = HT * VT;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, de, frame_start;
  logic [15:0] rgb;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  int m_h = 0, m_v = 0;
  bit m_started = 1'b0;

  logic       e_hs, e_vs, e_fs, e_de, in_row;
  logic [9:0] e_px, e_py;
  logic [15:0] sb_exp;

  always #20 vga_clk = ~vga_clk;

  assign pix_data = {pix_y[5:0], pix_x};

  vga_ctrl #(
    .V_SYNC  (VS),
    .V_BACK  (VB),
    .V_VALID (VV),
    .V_FRONT (VF)
  ) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .de          (de),
    .frame_start (frame_start)
  );

  // Reference raster position
  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_h <= 0;
      m_v <= 0;
      m_started <= 1'b0;
    end else begin
      m_started <= 1'b1;
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  always_comb begin
    in_row = (m_v >= VA) && (m_v < VA + VV);
    e_hs = m_started ? ((m_h < HS) ? 1'b0 : 1'b1) : 1'b1;
    e_vs = m_started ? ((m_v < VS) ? 1'b0 : 1'b1) : 1'b1;
    e_fs = m_started && (m_h == 0) && (m_v == 0);
    e_de = m_started && in_row && (m_h >= HA) && (m_h <= HA + 639);
    e_px = 10'h3FF;
    e_py = 10'h3FF;
    if (in_row && (m_h >= HA - 1) && (m_h <= HA + 638)) begin
      e_px = 10'(m_h - (HA - 1));
      e_py = 10'(m_v - VA);
    end
  end

  // Monitor: per-cycle timing checks and scoreboard pop whenever de presents a pixel
  always @(negedge vga_clk) begin
    checks++;
    if ({hsync, vsync, frame_start, de, pix_x, pix_y} !== {e_hs, e_vs, e_fs, e_de, e_px, e_py}) begin
      failures++;
      $display("FAIL timing h=%0d v=%0d got hs/vs/fs/de=%b%b%b%b x=%h y=%h want %b%b%b%b x=%h y=%h",
               m_h, m_v, hsync, vsync, frame_start, de, pix_x, pix_y,
               e_hs, e_vs, e_fs, e_de, e_px, e_py);
    end
    if (!e_de) begin
      checks++;
      if (rgb !== 16'h0000) begin
        failures++;
        $display("FAIL blank_rgb h=%0d v=%0d got rgb=%h want 0000", m_h, m_v, rgb);
      end
    end
    if (de === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_underflow h=%0d v=%0d got rgb=%h want no pixel", m_h, m_v, rgb);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rgb !== sb_exp) begin
          failures++;
          $display("FAIL pixel h=%0d v=%0d got rgb=%h want %h", m_h, m_v, rgb, sb_exp);
        end
      end
    end
  end

  task automatic push_frame(input int full_rows, input int tail_cols);
    for (int r = 0; r < full_rows; r++)
      for (int c = 0; c < 640; c++)
        exp_q.push_back({6'(r), 10'(c)});
    for (int c = 0; c < tail_cols; c++)
      exp_q.push_back({6'(full_rows), 10'(c)});
  endtask

  initial begin
    bit found;
    // Two full frames, a frame cut by reset at row 2 column 256, then one after restart.
    push_frame(VV, 0);
    push_frame(VV, 0);
    push_frame(2, 257);
    push_frame(VV, 0);

    repeat (10) @(negedge vga_clk);
    #5 sys_rst_n = 1'b1;
    repeat (2 * FRAME + 100) @(negedge vga_clk);

    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      @(negedge vga_clk);
      if (m_v == VA + 2 && m_h == 400) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_midframe got not_found want h=400 v=%0d", VA + 2);
    end

    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({de, rgb, pix_x, pix_y, frame_start, hsync, vsync} !==
        {1'b0, 16'h0000, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got de=%b rgb=%h x=%h y=%h fs=%b hs=%b vs=%b want 0 0000 3ff 3ff 0 1 1",
               de, rgb, pix_x, pix_y, frame_start, hsync, vsync);
    end

    repeat (3) @(negedge vga_clk);
    #5 sys_rst_n = 1'b1;
    repeat (FRAME + 50) @(negedge vga_clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pixels_left got %0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
